// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded fields and registers ALU decode.
// Optional operand forwarding is enabled by defining ID_EX_FWD_EN.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic [4:0]  in_rs1_addr,
    input  logic [4:0]  in_rs2_addr,
    input  logic [4:0]  in_rd_addr,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic [31:0] in_imm,
    input  logic        flush,
    input  logic        ex_ready,
    input  logic        exmem_wen,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_data,
    input  logic        memwb_wen,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_data,
    output logic        ex_valid,
    output logic [31:0] alu_ra,
    output logic [31:0] alu_rb,
    output logic [3:0]  alu_sel,
    output logic [4:0]  ex_rd,
    output logic        ex_wen,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs2_val
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        RA_RS1,
        RA_PC,
        RA_ZERO
    } ra_src_t;

    logic        accept;
    logic [3:0]  d_sel;
    ra_src_t     d_ra;
    logic        d_rb_imm;
    logic        d_wen;

    logic [4:0]  rs1_addr_q;
    logic [4:0]  rs2_addr_q;
    logic [31:0] rs1_data_q;
    logic [31:0] rs2_data_q;
    logic [31:0] imm_q;
    logic        wen_q;
    ra_src_t     ra_src_q;
    logic        rb_imm_q;

    logic [31:0] rs1v;
    logic [31:0] rs2v;

    assign in_ready = !ex_valid || ex_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Decode opcode into ALU select, operand sources and write enable.
    always_comb begin
        d_sel    = 4'b0000;
        d_ra     = RA_RS1;
        d_rb_imm = 1'b0;
        d_wen    = 1'b0;
        unique case (1'b1)
            (in_opcode == OPC_OP): begin
                d_sel = {in_funct3, in_funct7b5};
                d_wen = 1'b1;
            end
            (in_opcode == OPC_OPIMM): begin
                d_sel    = (in_funct3 == 3'b101) ?
                           {in_funct3, in_funct7b5} :
                           {in_funct3, 1'b0};
                d_rb_imm = 1'b1;
                d_wen    = 1'b1;
            end
            (in_opcode == OPC_LUI): begin
                d_ra     = RA_ZERO;
                d_rb_imm = 1'b1;
                d_wen    = 1'b1;
            end
            (in_opcode == OPC_AUIPC): begin
                d_ra     = RA_PC;
                d_rb_imm = 1'b1;
                d_wen    = 1'b1;
            end
            (in_opcode == OPC_LOAD): begin
                d_rb_imm = 1'b1;
                d_wen    = 1'b1;
            end
            (in_opcode == OPC_STORE): begin
                d_rb_imm = 1'b1;
            end
            default: begin
            end
        endcase
        if (in_rd_addr == 5'd0) begin
            d_wen = 1'b0;
        end
    end

    // Valid bit: flush beats accept, accept beats drain, stall holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // Payload registers load only on accept, so a stall holds them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pc      <= '0;
            ex_rd      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            alu_sel    <= 4'b0000;
            wen_q      <= 1'b0;
            ra_src_q   <= RA_RS1;
            rb_imm_q   <= 1'b0;
        end else if (accept) begin
            ex_pc      <= in_pc;
            ex_rd      <= in_rd_addr;
            rs1_addr_q <= in_rs1_addr;
            rs2_addr_q <= in_rs2_addr;
            rs1_data_q <= in_rs1_data;
            rs2_data_q <= in_rs2_data;
            imm_q      <= in_imm;
            alu_sel    <= d_sel;
            wen_q      <= d_wen;
            ra_src_q   <= d_ra;
            rb_imm_q   <= d_rb_imm;
        end
    end

`ifdef ID_EX_FWD_EN
    // Resolve operands every cycle; the younger EX/MEM result wins.
    always_comb begin
        rs1v = rs1_data_q;
        rs2v = rs2_data_q;
        if (memwb_wen && memwb_rd == rs1_addr_q && memwb_rd != 5'd0) begin
            rs1v = memwb_data;
        end
        if (exmem_wen && exmem_rd == rs1_addr_q && exmem_rd != 5'd0) begin
            rs1v = exmem_data;
        end
        if (memwb_wen && memwb_rd == rs2_addr_q && memwb_rd != 5'd0) begin
            rs2v = memwb_data;
        end
        if (exmem_wen && exmem_rd == rs2_addr_q && exmem_rd != 5'd0) begin
            rs2v = exmem_data;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_wen, exmem_rd, exmem_data,
                          memwb_wen, memwb_rd, memwb_data,
                          rs1_addr_q, rs2_addr_q};
    assign rs1v = rs1_data_q;
    assign rs2v = rs2_data_q;
`endif

    // Select ALU operand A from register, PC or zero.
    always_comb begin
        unique case (ra_src_q)
            RA_PC:   alu_ra = ex_pc;
            RA_ZERO: alu_ra = 32'd0;
            default: alu_ra = rs1v;
        endcase
    end

    assign alu_rb     = rb_imm_q ? imm_q : rs2v;
    assign ex_rs2_val = rs2v;
    assign ex_wen     = ex_valid && wen_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock and reset: clk input 1 rising-edge clock; rst input 1 asynchronous, active-high reset.
REQ-002 SHALL have upstream handshake: in_valid input 1 decoded instruction present; in_ready output 1 stage can accept.
REQ-003 SHALL have decoded fields: in_pc input 32; in_opcode input 7; in_funct3 input 3; in_funct7b5 input 1 (instr bit 30); in_rs1_addr, in_rs2_addr, in_rd_addr input 5 each; in_rs1_data, in_rs2_data, in_imm input 32 each.
REQ-004 SHALL have flush input 1: discard held instruction.
REQ-005 SHALL have ex_ready input 1: downstream consumes current output this cycle.
REQ-006 SHALL have forwarding sources: exmem_wen input 1, exmem_rd input 5, exmem_data input 32; memwb_wen input 1, memwb_rd input 5, memwb_data input 32.
REQ-007 SHALL have outputs: ex_valid 1; alu_ra 32; alu_rb 32; alu_sel 4; ex_rd 5; ex_wen 1; ex_pc 32; ex_rs2_val 32 (forwarded rs2, store data).

Function
REQ-008 in_ready SHALL equal (!ex_valid || ex_ready), combinational.
REQ-009 Accept SHALL occur when in_valid && in_ready && !flush; all fields latched on that edge; ex_valid=1 next cycle (latency 1).
REQ-010 ex_valid && !ex_ready SHALL hold all latched fields unchanged (stall).
REQ-011 ex_valid && ex_ready without accept SHALL clear ex_valid next edge.
REQ-012 flush SHALL clear ex_valid next edge and block accept that cycle, priority over stall and accept.
REQ-013 alu_sel encoding SHALL be: add 0000, sub 0001, sll 0010, slt 0100, sltu 0110, xor 1000, srl 1010, sra 1011, or 1100, and 1110.
REQ-014 OP (0110011): alu_sel={funct3,funct7b5}; ra=rs1v; rb=rs2v; ex_wen=1.
REQ-015 OP-IMM (0010011): alu_sel={funct3,funct7b5} when funct3=101, else {funct3,0}; ra=rs1v; rb=imm; ex_wen=1.
REQ-016 LUI (0110111): sel 0000, ra=0, rb=imm, ex_wen=1; AUIPC (0010111): sel 0000, ra=pc, rb=imm, ex_wen=1.
REQ-017 LOAD (0000011): sel 0000, ra=rs1v, rb=imm, ex_wen=1; STORE (0100011): sel 0000, ra=rs1v, rb=imm, ex_wen=0.
REQ-018 Any other opcode: sel 0000, ra=rs1v, rb=rs2v, ex_wen=0.
REQ-019 ex_wen SHALL be forced 0 when latched rd=0.
REQ-020 rs1v/rs2v SHALL be resolved combinationally at output from latched rs addr/data: EX/MEM match first, then MEM/WB, else latched data; match = wen && rd==rs addr && rd!=0.
REQ-021 Forwarding SHALL re-evaluate every cycle during a stall (late-arriving producer seen).
REQ-022 alu_sel, ex_wen SHALL be registered decode results; ex_wen output SHALL read 0 when ex_valid=0.

Reset
REQ-023 rst SHALL asynchronously clear ex_valid, ex_pc, ex_rd, latched data/imm/addr to 0, alu_sel to 0000, ex_wen to 0.
REQ-024 rst asserted mid-stall SHALL drop the held instruction; in_ready=1 while rst deasserted and ex_valid=0.
REQ-025 First accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro ID_EX_FWD_EN SHALL gate forwarding: defined -> REQ-020/021 apply; undefined -> rs1v/rs2v are latched data only, exmem_*/memwb_* inputs ignored.

Verification
REQ-027 Reset: assert rst mid-operation -> ex_valid=0, alu_sel=0000, ex_wen=0 immediately, in_ready=1.
REQ-028 R-type sub: opcode 0110011, funct3 000, b5=1, rs1=5, rs2=3, rd=4 -> next cycle ex_valid=1, sel 0001, ra=5, rb=3, ex_wen=1.
REQ-029 srai vs addi: OP-IMM funct3 101 b5=1 -> sel 1011; funct3 000 b5=1 imm -4 -> sel 0000, rb=0xFFFFFFFC.
REQ-030 Forward priority (ID_EX_FWD_EN): rs1_addr=7, exmem rd=7 data 0x11, memwb rd=7 data 0x22 -> ra=0x11; exmem_wen=0 -> ra=0x22; rd=0 producers -> latched data.
REQ-031 Stall: ex_ready=0 three cycles with in_valid=1 -> in_ready=0, outputs stable; ex_ready=1 -> next instruction appears following cycle.
REQ-032 Flush with simultaneous in_valid=1, ex_ready=1 -> ex_valid=0 next cycle, new instruction not captured.
